// File: rtl/bcd_seg_scan.sv
// Scans two captured 4-digit BCD values onto an 8-digit common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros within each 4-digit group.
module bcd_seg_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DV10,
  input  logic [3:0] DV11,
  input  logic [3:0] DV12,
  input  logic [3:0] DV13,
  input  logic [3:0] DV20,
  input  logic [3:0] DV21,
  input  logic [3:0] DV22,
  input  logic [3:0] DV23,
  input  logic       upd,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_pending;
  logic [3:0]    r_sh [8];

  logic [3:0]    w_in [8];
  logic          w_tick;
  logic          w_bnd;
  logic [7:0]    w_lz;
  logic          w_blank;

  assign w_in   = '{DV10, DV11, DV12, DV13, DV20, DV21, DV22, DV23};
  assign w_tick = (r_cnt == CNT_MAX);
  assign w_bnd  = w_tick && (r_idx == 3'd7);
  assign dp     = 1'b1;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // w_lz[k]: slot k and every higher slot of its group are zero (ones slots excluded).
  always_comb begin
    w_lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 0; k < 8; k++) begin
      w_lz[k] = ((k % 4) != 0);
      for (int j = k; j < (k / 4) * 4 + 4; j++) begin
        if (r_sh[j] != 4'd0) w_lz[k] = 1'b0;
      end
    end
`else
    w_lz = '0;
`endif
    w_blank = w_lz[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      for (int k = 0; k < 8; k++) r_sh[k] <= 4'd0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 3'd1;
      // A request arriving in the boundary cycle is consumed immediately.
      r_pending <= w_bnd ? 1'b0 : (r_pending | upd);
      if (w_bnd && (r_pending || upd)) begin
        for (int k = 0; k < 8; k++) r_sh[k] <= w_in[k];
      end
      an         <= w_blank ? 8'hFF : ~(8'b1 << r_idx);
      seg        <= w_blank ? 7'h7F : decode(r_sh[r_idx]);
      frame_done <= w_bnd;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan at CLK_DIV=4: per-cycle scoreboard plus slot-level spot checks.
module tb_bcd_seg_scan;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [15:0] dv1 = '0;
  logic [15:0] dv2 = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];

  bcd_seg_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .DV10(dv1[3:0]), .DV11(dv1[7:4]), .DV12(dv1[11:8]), .DV13(dv1[15:12]),
    .DV20(dv2[3:0]), .DV21(dv2[7:4]), .DV22(dv2[11:8]), .DV23(dv2[15:12]),
    .upd(upd), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] m_sh [8];
  int         m_cnt  = 0;
  int         m_idx  = 0;
  bit         m_pend = 0;
  bit         m_live = 0;
  bit         m_tick, m_bnd;

  function automatic bit m_blank(input int i);
`ifdef LEADING_ZERO_BLANK_EN
    int base;
    base = i & 4;
    if ((i & 3) == 0) return 1'b0;
    for (int k = i; k < base + 4; k++) if (m_sh[k] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_an(input int i);
    logic [7:0] one;
    one = 8'd1;
    if (m_blank(i)) return 8'hFF;
    return ~(one << i);
  endfunction

  function automatic logic [6:0] m_seg(input int i);
    if (m_blank(i) || m_sh[i] > 4'd9) return 7'h7F;
    return seg_tab[m_sh[i]];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 0; m_live = 0;
      for (int k = 0; k < 8; k++) m_sh[k] = 4'd0;
      exp_q.delete();
    end else begin
      m_tick = (m_cnt == CLK_DIV - 1);
      m_bnd  = m_tick && (m_idx == 7);
      exp_q.push_back({m_an(m_idx), m_seg(m_idx), 1'b1, m_bnd});
      if (m_bnd && (m_pend || upd)) begin
        for (int k = 0; k < 4; k++) begin
          m_sh[k]     = dv1[4*k +: 4];
          m_sh[k + 4] = dv2[4*k +: 4];
        end
      end
      m_pend = m_bnd ? 1'b0 : (m_pend | upd);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      if (m_tick) m_idx = (m_idx + 1) % 8;
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && m_live) begin
      if (exp_q.size() == 0) check("q_empty", 17'd0, 17'd1);
      else check("cycle", {an, seg, dp, frame_done}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] got_an  [8];
  logic [6:0] got_seg [8];

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) check("fd_timeout", 17'd0, 17'd1);
  endtask

  task automatic pulse_upd(input int len);
    @(negedge clk);
    upd = 1'b1;
    repeat (len) @(negedge clk);
    upd = 1'b0;
  endtask

  // Called at the frame_done negedge; slot 0 of the new frame shows one cycle later.
  task automatic sample_frame_now();
    for (int s = 0; s < 8; s++) begin
      repeat ((s == 0) ? 1 : CLK_DIV) @(negedge clk);
      got_an[s]  = an;
      got_seg[s] = seg;
    end
  endtask

  task automatic sample_frame();
    int n;
    wait_fd(n);
    sample_frame_now();
  endtask

  task automatic check_slot(input string tag, input int s, input logic [7:0] ea, input logic [6:0] es);
    check($sformatf("%s_an%0d", tag, s), 17'(got_an[s]), 17'(ea));
    check($sformatf("%s_seg%0d", tag, s), 17'(got_seg[s]), 17'(es));
  endtask

  function automatic logic [7:0] slot_an(input int s);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << s);
  endfunction

  // ---------------- stimulus ----------------
  logic [6:0] t2_seg [8] = '{7'h24, 7'h79, 7'h19, 7'h40, 7'h30, 7'h24, 7'h79, 7'h30};
  logic [6:0] t6_seg [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79, 7'h19, 7'h40};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_out", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    #2 rst = 1'b0;
    @(negedge clk);
    check("rel_out", {an, seg, dp, frame_done}, {8'hFE, 7'h40, 1'b1, 1'b0});

    // Capture and frame period
    dv1 = 16'h0412; dv2 = 16'h3123;
    pulse_upd(1);
    sample_frame();
    for (int s = 0; s < 8; s++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 3) check_slot("t2", s, 8'hFF, 7'h7F);
      else check_slot("t2", s, slot_an(s), t2_seg[s]);
`else
      check_slot("t2", s, slot_an(s), t2_seg[s]);
`endif
    end
    wait_fd(n);
    wait_fd(n);
    check("fd_period", 17'(n), 17'(32));

    // Frame integrity: update issued mid-frame at idx=2
    repeat (2 * CLK_DIV - 1) @(negedge clk);
    dv1 = 16'h9876;
    pulse_upd(1);
    sample_frame();
    check_slot("t3", 0, 8'hFE, 7'h02);
    check_slot("t3", 1, 8'hFD, 7'h78);
    check_slot("t3", 2, 8'hFB, 7'h00);
    check_slot("t3", 3, 8'hF7, 7'h10);

    // upd only in the boundary cycle
    wait_fd(n);
    repeat (31) @(negedge clk);
    dv1 = 16'h5555; dv2 = 16'h1111;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    check("t4_fd", 17'(frame_done), 17'd1);
    dv1 = 16'h8888; dv2 = 16'h8888;
    sample_frame_now();
    check_slot("t4a", 0, 8'hFE, 7'h12);
    check_slot("t4a", 4, 8'hEF, 7'h79);
    sample_frame();
    check_slot("t4b", 0, 8'hFE, 7'h12);
    check_slot("t4b", 7, 8'h7F, 7'h79);

    // Invalid BCD digit
    dv1 = 16'h1C34;
    pulse_upd(2);
    sample_frame();
    check_slot("t5", 2, 8'hFB, 7'h7F);
    check_slot("t5", 1, 8'hFD, 7'h30);

    // Leading zeros
    dv1 = 16'h0000; dv2 = 16'h0412;
    pulse_upd(1);
    sample_frame();
    for (int s = 0; s < 8; s++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 1 || s == 2 || s == 3 || s == 7) check_slot("t6", s, 8'hFF, 7'h7F);
      else check_slot("t6", s, slot_an(s), t6_seg[s]);
`else
      check_slot("t6", s, slot_an(s), t6_seg[s]);
`endif
    end

    // Reset asserted mid-cycle, mid-frame
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("mid_rst", {an, seg, dp, frame_done}, {8'hFF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rel", {an, seg, dp, frame_done}, {8'hFE, 7'h40, 1'b1, 1'b0});
    dv1 = 16'h9999; dv2 = 16'h9999;
    repeat (20) @(negedge clk);

    // Random captures, checked by the scoreboard
    for (int r = 0; r < 6; r++) begin
      dv1 = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
      dv2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (r % 3 == 2) begin
        dv1[15:8] = 8'h00;
        dv2[15:12] = 4'h0;
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
      pulse_upd($urandom_range(1, 3));
      repeat ($urandom_range(10, 50)) @(negedge clk);
    end
    wait_fd(n);
    repeat (33) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
